inst_encoder: RTL and testbench

Field-to-word RV32I instruction encoder, the inverse of the immediate generator. It takes decoded fields (format, opcode, registers, functs, signed immediate) over a valid/ready handshake, then packs and range-checks them into a 32-bit instruction word. Each word is tagged with a running instruction address and queued in a small output FIFO. It feeds the instruction-memory loader and the self-test program builder.

---
 rtl/enc_pkg.sv | 24 ++
 rtl/inst_pack.sv | 60 ++++++
 rtl/inst_encoder.sv | 91 +++++++++
 tb/tb_inst_encoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types for the RV32I field-to-word encoder: format codes,
// the canonical NOP and the output FIFO entry layout.
package enc_pkg;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_SB   = 3'd3,
      FMT_U    = 3'd4,
      FMT_UJ   = 3'd5,
      FMT_CSR  = 3'd6,
      FMT_RSVD = 3'd7
   } fmt_e;

   localparam logic [31:0] ENC_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
      logic        err;
   } fifo_entry_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: places decoded fields into an RV32I word and flags
// immediates that do not fit the chosen format (the word is still emitted).
module inst_pack
   import enc_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        err
);

   // An immediate fits N signed bits when all bits above N-1 equal the sign bit.
   logic fits12, fits13, fits21;
   assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
   assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

   always_comb begin
      inst = ENC_NOP;
      err  = 1'b0;
      case (fmt_e'(fmt))
         FMT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            inst = {imm[11:0], rs1, funct3, rd, opcode};
            err  = ~fits12;
         end
         FMT_S: begin
            inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            err  = ~fits12;
         end
         FMT_SB: begin
            inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            err  = ~fits13 | imm[0];
         end
         FMT_U: begin
            inst = {imm[31:12], rd, opcode};
            err  = |imm[11:0];
         end
         FMT_UJ: begin
            inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            err  = ~fits21 | imm[0];
         end
         FMT_CSR: begin
            inst = {funct7, rs2, imm[4:0], funct3, rd, opcode};
            err  = |imm[31:5];
         end
         default: begin
            inst = ENC_NOP;
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Encoder top: accepts field bundles, packs them, tags each with a running
// address and queues them in a small FIFO; also counts erroneous inputs.
module inst_encoder
   import enc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter int          ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_fmt,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [31:0]          in_imm,
   input  logic                 addr_load,
   input  logic [31:0]          addr_val,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_inst,
   output logic [31:0]          out_addr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   fifo_entry_t mem [FIFO_DEPTH];
   fifo_entry_t head;
   logic [PTR_W:0] wr_ptr, rd_ptr;
   logic [31:0] addr_cnt, tag;
   logic [31:0] pack_inst;
   logic pack_err, full, empty, push, pop;

   inst_pack u_pack (
      .fmt    (in_fmt),
      .opcode (in_opcode),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .funct3 (in_funct3),
      .funct7 (in_funct7),
      .imm    (in_imm),
      .inst   (pack_inst),
      .err    (pack_err)
   );

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign in_ready  = ~full;
   assign push      = in_valid & ~full;
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign tag       = addr_load ? addr_val : addr_cnt;

   assign head     = mem[rd_ptr[PTR_W-1:0]];
   assign out_inst = out_valid ? head.inst : 32'h0;
   assign out_addr = out_valid ? head.addr : 32'h0;
   assign out_err  = out_valid & head.err;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         addr_cnt <= BASE_ADDR;
         err_cnt  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= '{inst: pack_inst, addr: tag, err: pack_err};
            wr_ptr   <= wr_ptr + (PTR_W+1)'(1);
            addr_cnt <= tag + 32'd4;
            if (pack_err && (err_cnt != '1))
               err_cnt <= err_cnt + ERR_CNT_W'(1);
         end else if (addr_load) begin
            addr_cnt <= addr_val;
         end
         if (pop)
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder: a queue-based reference
// model plus directed scenarios for packing, back-pressure, wrap and reset.
module tb_inst_encoder;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          DEPTH = 2;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, addr_load, out_valid, out_ready, out_err;
   logic [2:0]  in_fmt, in_funct3;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm, addr_val, out_inst, out_addr;
   logic [7:0]  err_cnt;

   inst_encoder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_imm(in_imm), .addr_load(addr_load), .addr_val(addr_val),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] addr;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_addr;
   int          m_err;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
      end
   endtask

   // Reference encoding derived directly from the field layout table.
   function automatic logic [31:0] refInst(input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
      case (fmt)
         3'd0: return {f7, rs2, rs1, f3, rd, op};
         3'd1: return {imm[11:0], rs1, f3, rd, op};
         3'd2: return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         3'd3: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         3'd4: return {imm[31:12], rd, op};
         3'd5: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         3'd6: return {f7, rs2, imm[4:0], f3, rd, op};
         default: return 32'h0000_0013;
      endcase
   endfunction

   // Range rules expressed as plain integer arithmetic on the signed value.
   function automatic logic refErr(input logic [2:0] fmt, input logic [31:0] imm);
      longint s;
      longint u;
      s = longint'($signed(imm));
      u = longint'(imm);
      case (fmt)
         3'd0: return 1'b0;
         3'd1, 3'd2: return (s < -2048) || (s > 2047);
         3'd3: return (s < -4096) || (s > 4094) || (s % 2 != 0);
         3'd4: return (u % 4096) != 0;
         3'd5: return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
         3'd6: return u > 31;
         default: return 1'b1;
      endcase
   endfunction

   task automatic checkModel();
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < DEPTH});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      checkOutput("err_cnt", {24'd0, err_cnt}, 32'(m_err));
      if (exp_q.size() > 0) begin
         checkOutput("out_inst", out_inst, exp_q[0].inst);
         checkOutput("out_addr", out_addr, exp_q[0].addr);
         checkOutput("out_err", {31'd0, out_err}, {31'd0, exp_q[0].err});
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
      input logic ordy, input logic ald, input logic [31:0] aval);
      logic acc, pp;
      exp_t e;
      in_valid = v; in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
      in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      out_ready = ordy; addr_load = ald; addr_val = aval;
      @(negedge clk);
      checkModel();
      acc = v && (exp_q.size() < DEPTH);
      pp  = (exp_q.size() > 0) && ordy;
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
         e.addr = ald ? aval : m_addr;
         e.inst = refInst(fmt, op, rd, rs1, rs2, f3, f7, imm);
         e.err  = refErr(fmt, imm);
         exp_q.push_back(e);
         m_addr = e.addr + 32'd4;
         if (e.err && m_err < 255) m_err++;
      end else if (ald) begin
         m_addr = aval;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      m_addr = BASE;
      m_err  = 0;
   endtask

   task automatic idle(input logic ordy);
      applyStimulus(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, ordy, 1'b0, 32'd0);
   endtask

   int bnd[16] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, -4098,
                   1048574, -1048576, 1048576, 31, 32, 0, 4096, -3};

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0;
      in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      addr_load = 1'b0; addr_val = '0; out_ready = 1'b0;
      doReset();
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_inst", out_inst, 32'd0);
      checkOutput("rst_out_addr", out_addr, 32'd0);
      checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
      checkOutput("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Packing examples with the consumer always ready.
      applyStimulus(1, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 0, 0);
      checkOutput("i_inst", out_inst, 32'h0050_0093);
      checkOutput("i_addr", out_addr, BASE);
      checkOutput("i_err", {31'd0, out_err}, 32'd0);
      applyStimulus(1, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1, 0, 0);
      checkOutput("sb_inst", out_inst, 32'hFE20_8EE3);
      checkOutput("sb_err", {31'd0, out_err}, 32'd0);
      applyStimulus(1, 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd3, 1, 0, 0);
      checkOutput("sb_odd_err", {31'd0, out_err}, 32'd1);
      checkOutput("sb_odd_cnt", {24'd0, err_cnt}, 32'd1);
      applyStimulus(1, 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 0, 0);
      checkOutput("uj_inst", out_inst, 32'h0010_00EF);
      applyStimulus(1, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1, 0, 0);
      checkOutput("i_big_inst", out_inst, 32'h0000_0093);
      checkOutput("i_big_err", {31'd0, out_err}, 32'd1);
      checkOutput("i_big_cnt", {24'd0, err_cnt}, 32'd2);
      idle(1);

      // Back-pressure: two accepts fill the FIFO, the third waits.
      doReset();
      applyStimulus(1, 3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 0, 0, 0, 0);
      applyStimulus(1, 3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 0, 0, 0, 0);
      checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("full_head_addr", out_addr, BASE);
      applyStimulus(1, 3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'd0, 0, 0, 0, 0);
      applyStimulus(1, 3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'd0, 0, 1, 0, 0);
      checkOutput("drain_addr1", out_addr, BASE + 32'd4);
      applyStimulus(1, 3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'd0, 0, 1, 0, 0);
      checkOutput("drain_addr2", out_addr, BASE + 32'd8);
      idle(1);

      // Address load coinciding with an accept, then wrap past 2^32.
      applyStimulus(1, 3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1, 1, 32'hFFFF_FFFC);
      checkOutput("load_tag", out_addr, 32'hFFFF_FFFC);
      applyStimulus(1, 3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1, 0, 0);
      checkOutput("wrap_tag", out_addr, 32'h0000_0000);
      idle(1);

      // Reset with a full FIFO and three counted errors.
      doReset();
      applyStimulus(1, 3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0, 0, 0, 0);
      idle(1);
      applyStimulus(1, 3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0, 0, 0, 0);
      applyStimulus(1, 3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0, 0, 0, 0);
      checkOutput("pre_rst_cnt", {24'd0, err_cnt}, 32'd3);
      checkOutput("rsvd_inst", out_inst, 32'h0000_0013);
      doReset();
      checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("mid_rst_cnt", {24'd0, err_cnt}, 32'd0);
      checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(1, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1, 0, 0);
      checkOutput("post_rst_tag", out_addr, BASE);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] imm;
         case ($urandom_range(0, 3))
            0: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
            1: imm = $urandom();
            2: imm = 32'(bnd[$urandom_range(0, 15)]);
            default: imm = $urandom() & 32'hFFFF_F000;
         endcase
         applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom()), 7'($urandom()),
            5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()), 7'($urandom()),
            imm, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), $urandom());
      end
      idle(1);
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
